// File: rtl/pit_wb_arbiter_if.sv
// Bus bundle for pit_wb_arbiter: both master ports plus the shared PIT slave port.
// Signal suffixes are written from the arbiter's point of view (_i = into the arbiter).
// slave  : the arbiter's view (it is the slave of both masters).
// master : the environment's view (both masters and the PIT register slave).
interface pit_wb_arbiter_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 3,
    parameter int S_WIDTH = 2
);
    // Master 0 port
    logic               m0_cyc_i;
    logic               m0_stb_i;
    logic               m0_we_i;
    logic [A_WIDTH-1:0] m0_adr_i;
    logic [D_WIDTH-1:0] m0_dat_i;
    logic [S_WIDTH-1:0] m0_sel_i;
    logic               m0_ack_o;
    logic               m0_err_o;

    // Master 1 port
    logic               m1_cyc_i;
    logic               m1_stb_i;
    logic               m1_we_i;
    logic [A_WIDTH-1:0] m1_adr_i;
    logic [D_WIDTH-1:0] m1_dat_i;
    logic [S_WIDTH-1:0] m1_sel_i;
    logic               m1_ack_o;
    logic               m1_err_o;

    // Read data shared by both masters
    logic [D_WIDTH-1:0] m_dat_o;

    // PIT slave port
    logic               s_cyc_o;
    logic               s_stb_o;
    logic               s_we_o;
    logic [A_WIDTH-1:0] s_adr_o;
    logic [D_WIDTH-1:0] s_dat_o;
    logic [S_WIDTH-1:0] s_sel_o;
    logic               s_ack_i;
    logic [D_WIDTH-1:0] s_dat_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        output m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        output m1_ack_o, m1_err_o,
        output m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        input  m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        input  m1_ack_o, m1_err_o,
        input  m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_dat_i
    );
endinterface

// File: rtl/pit_wb_arbiter.sv
// pit_wb_arbiter: two-master round-robin Wishbone arbiter in front of the PIT
// register slave. One whole bus cycle (cyc high) is granted at a time and is
// never preempted; handover between masters has no idle bubble.
//
// Handshake: a master owns the slave while its grant bit is set and it keeps
// cyc high; each access is stb high until s_ack_i (or err) is returned in the
// same cycle, and acks/errs reach only the granted master with stb high.
//
// Optional build macro PIT_ARB_TIMEOUT_EN adds a stall watchdog: after
// TO_CYCLES unacknowledged strobe cycles the granted master gets a one-cycle
// err pulse and the slave strobe is suppressed for that cycle. Without the
// macro the err outputs are constant 0.
//
// gnt_o is the FSM state register itself (IDLE=00, G0=01, G1=10), so it
// doubles as the state debug output.
module pit_wb_arbiter #(
    parameter int D_WIDTH   = 16,
    parameter int A_WIDTH   = 3,
    parameter int S_WIDTH   = 2,
    parameter int TO_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 arst_i,
    input  logic                 wb_rst_i,
    pit_wb_arbiter_if.slave      bus,
    output logic [1:0]           gnt_o
);

    // One-hot encoding so the state can drive gnt_o directly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // master granted most recently; loses the next tie

    logic   g0, g1;
    logic   stb_raw;          // granted master's strobe before watchdog gating
    logic   to_hit;           // watchdog fires this cycle

    // Next-state: round-robin on ties, hold while the owner keeps cyc,
    // hand over directly when the owner lets go and the other is waiting.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && !bus.m1_cyc_i) begin
                    state_d = G0;
                end else if (bus.m1_cyc_i && !bus.m0_cyc_i) begin
                    state_d = G1;
                end else if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_q ? G0 : G1;
                end
            end
            G0: begin
                if (!bus.m0_cyc_i) begin
                    state_d = bus.m1_cyc_i ? G1 : IDLE;
                end
            end
            G1: begin
                if (!bus.m1_cyc_i) begin
                    state_d = bus.m0_cyc_i ? G0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == G0 && state_q != G0) begin
            last_d = 1'b0;
        end else if (state_d == G1 && state_q != G1) begin
            last_d = 1'b1;
        end
    end

    // Grant state and round-robin pointer; last resets to 1 so m0 wins first.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o = state_q;
    assign g0    = (state_q == G0);
    assign g1    = (state_q == G1);

    assign stb_raw = (g0 && bus.m0_stb_i) || (g1 && bus.m1_stb_i);

`ifdef PIT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TO_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

    // The watchdog fires on the TO_CYCLES-th consecutive stalled strobe cycle.
    assign to_hit = stb_raw && !bus.s_ack_i && (to_cnt_q == CNT_W'(TO_CYCLES - 1));

    // Stall counter: restart on grant change, on any ack, and after firing.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if ((state_d != state_q) || bus.s_ack_i || to_hit) begin
            to_cnt_d = '0;
        end else if (stb_raw) begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            to_cnt_q <= '0;
        end else if (wb_rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign bus.m0_err_o = to_hit && g0 && bus.m0_stb_i;
    assign bus.m1_err_o = to_hit && g1 && bus.m1_stb_i;
`else
    // No watchdog: a stalled slave holds the granted master until it acks.
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES < 2);
    assign to_hit           = 1'b0;
    assign bus.m0_err_o     = 1'b0;
    assign bus.m1_err_o     = 1'b0;
`endif

    // Slave-side mux: the granted master's request, all zero when idle.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        if (g0) begin
            bus.s_cyc_o = bus.m0_cyc_i;
            bus.s_we_o  = bus.m0_we_i;
            bus.s_adr_o = bus.m0_adr_i;
            bus.s_dat_o = bus.m0_dat_i;
            bus.s_sel_o = bus.m0_sel_i;
        end else if (g1) begin
            bus.s_cyc_o = bus.m1_cyc_i;
            bus.s_we_o  = bus.m1_we_i;
            bus.s_adr_o = bus.m1_adr_i;
            bus.s_dat_o = bus.m1_dat_i;
            bus.s_sel_o = bus.m1_sel_i;
        end
    end

    assign bus.s_stb_o = stb_raw && !to_hit;

    // Return path: ack only to the granted master with an active strobe;
    // a spurious ack while idle reaches nobody.
    assign bus.m0_ack_o = bus.s_ack_i && g0 && bus.m0_stb_i;
    assign bus.m1_ack_o = bus.s_ack_i && g1 && bus.m1_stb_i;
    assign bus.m_dat_o  = (g0 || g1) ? bus.s_dat_i : '0;

endmodule
